// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard, memory-hold and debug-halt stall sequencer
// Outputs are combinational from state and ID/EX/MEM observations.
module hazard_stall_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic             ID_UsesRs1,
    input  logic             ID_UsesRs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Access,
    input  logic             MEM_Ack,
    input  logic             dbg_halt_req,
    output logic             nopMux_Select,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             Pipe_Hold,
    output logic             dbg_halt_ack,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);
    localparam logic [3:0]      DR_MAX = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      drain_q;
    logic [3:0]      drain_d;
    logic [TO_W-1:0] to_q;
    logic [TO_W-1:0] to_d;
    logic            timeout_hit;
    logic            run_cases;
    logic            memhold;
    logic            loaduse;

    assign memhold = MEM_Access & ~MEM_Ack;
    assign loaduse = EX_MemRead & (EX_Rd != 5'd0) &
                     ((ID_UsesRs1 & (ID_Rs1 == EX_Rd)) |
                      (ID_UsesRs2 & (ID_Rs2 == EX_Rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_q     <= '0;
            to_q        <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            to_q    <= to_d;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
            if (!PCWrite && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        to_d          = to_q;
        timeout_hit   = 1'b0;
        run_cases     = 1'b0;
        nopMux_Select = 1'b0;
        PCWrite       = 1'b1;
        IFID_Write    = 1'b1;
        IFID_Flush    = 1'b0;
        Pipe_Hold     = 1'b0;
        dbg_halt_ack  = 1'b0;

        case (state_q)
            RUN: begin
                if (memhold) begin
                    Pipe_Hold  = 1'b1;
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    state_d    = MEM_WAIT;
                end else begin
                    run_cases = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!MEM_Ack) begin
                    Pipe_Hold  = 1'b1;
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    if (to_q != TO_MAX) begin
                        to_d = to_q + 1'b1;
                    end
                    timeout_hit = (to_d == TO_MAX);
                end else begin
                    // Release cycle behaves like an ordinary RUN cycle
                    to_d      = '0;
                    state_d   = RUN;
                    run_cases = 1'b1;
                end
            end
            DRAIN: begin
                nopMux_Select = 1'b1;
                PCWrite       = 1'b0;
                IFID_Write    = 1'b0;
                if (memhold) begin
                    Pipe_Hold = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                    if (drain_d == DR_MAX) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                nopMux_Select = 1'b1;
                PCWrite       = 1'b0;
                IFID_Write    = 1'b0;
                dbg_halt_ack  = dbg_halt_req;
                if (!dbg_halt_req) begin
                    drain_d = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Branch beats load-use (ID is wrong-path); both defer halt acceptance
        if (run_cases) begin
            if (EX_BranchTaken) begin
                IFID_Flush    = 1'b1;
                nopMux_Select = 1'b1;
                PCWrite       = 1'b1;
            end else if (loaduse) begin
                nopMux_Select = 1'b1;
                PCWrite       = 1'b0;
                IFID_Write    = 1'b0;
            end else if (dbg_halt_req) begin
                nopMux_Select = 1'b1;
                PCWrite       = 1'b0;
                IFID_Write    = 1'b0;
                drain_d       = 4'd1;
                state_d       = (DR_MAX == 4'd1) ? HALTED : DRAIN;
            end
        end

        if (!rst_n) begin
            nopMux_Select = 1'b1;
            PCWrite       = 1'b0;
            IFID_Write    = 1'b0;
            IFID_Flush    = 1'b0;
            Pipe_Hold     = 1'b0;
            dbg_halt_ack  = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       ma;
        logic       mk;
        logic       hr;
    } stim_t;

    // {nopMux_Select, PCWrite, IFID_Write, IFID_Flush, Pipe_Hold, dbg_halt_ack}
    localparam logic [5:0] NORM = 6'b011000;
    localparam logic [5:0] BUB  = 6'b100000;
    localparam logic [5:0] BR   = 6'b111100;
    localparam logic [5:0] HOLD = 6'b000010;
    localparam logic [5:0] DRNH = 6'b100010;
    localparam logic [5:0] HLT  = 6'b100001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ID_Rs1, ID_Rs2, EX_Rd;
    logic        ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_BranchTaken;
    logic        MEM_Access, MEM_Ack, dbg_halt_req;
    logic        mem_access_t, tmo_en;
    logic        nopMux_Select, PCWrite, IFID_Write, IFID_Flush, Pipe_Hold, dbg_halt_ack;
    logic        mem_timeout;
    logic [15:0] stall_cnt;
    logic        t_sel, t_pcw, t_ifw, t_flush, t_hold, t_ack, t_mem_timeout;
    logic [15:0] t_stall_cnt;
    logic [5:0]  outv;
    logic [5:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;
    assign outv = {nopMux_Select, PCWrite, IFID_Write, IFID_Flush, Pipe_Hold, dbg_halt_ack};

    hazard_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
        .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .EX_BranchTaken(EX_BranchTaken),
        .MEM_Access(MEM_Access), .MEM_Ack(MEM_Ack), .dbg_halt_req(dbg_halt_req),
        .nopMux_Select(nopMux_Select), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .Pipe_Hold(Pipe_Hold), .dbg_halt_ack(dbg_halt_ack),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.MEM_TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
        .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .EX_BranchTaken(EX_BranchTaken),
        .MEM_Access(mem_access_t), .MEM_Ack(MEM_Ack), .dbg_halt_req(dbg_halt_req),
        .nopMux_Select(t_sel), .PCWrite(t_pcw), .IFID_Write(t_ifw),
        .IFID_Flush(t_flush), .Pipe_Hold(t_hold), .dbg_halt_ack(t_ack),
        .mem_timeout(t_mem_timeout), .stall_cnt(t_stall_cnt)
    );

    function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic mr,
                                 input logic [4:0] rd, input logic br, input logic ma,
                                 input logic mkk, input logic hr);
        stim_t s;
        s = {rs1, rs2, u1, u2, mr, rd, br, ma, mkk, hr};
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic stim_t req(input logic hr);
        return mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, hr);
    endfunction

    task automatic apply(input stim_t s);
        ID_Rs1         = s.rs1;
        ID_Rs2         = s.rs2;
        ID_UsesRs1     = s.u1;
        ID_UsesRs2     = s.u2;
        EX_MemRead     = s.mr;
        EX_Rd          = s.rd;
        EX_BranchTaken = s.br;
        MEM_Access     = s.ma;
        MEM_Ack        = s.mk;
        dbg_halt_req   = s.hr;
        mem_access_t   = s.ma & tmo_en;
    endtask

    task automatic test_reset();
        logic [5:0] want;
        apply(mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(BUB);
        @(negedge clk);
        want = exp_q.pop_front();
        checks++; if (outv !== want) begin errors++; $display("FAIL reset outputs got %b want %b", outv, want); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset mem_timeout got %b want 0", mem_timeout); end
        checks++; if (t_mem_timeout !== 1'b0) begin errors++; $display("FAIL reset t_mem_timeout got %b want 0", t_mem_timeout); end
        @(posedge clk); #1;
        apply(idle());
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        stim_t s[7];
        logic [5:0] e[7];
        logic [5:0] want;
        s[0] = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); e[0] = BUB;
        s[1] = idle();                                                           e[1] = NORM;
        s[2] = mk(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0); e[2] = BUB;
        s[3] = mk(5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); e[3] = NORM;
        s[4] = mk(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); e[4] = NORM;
        s[5] = mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); e[5] = NORM;
        s[6] = idle();                                                           e[6] = NORM;
        for (int i = 0; i < 7; i++) begin
            apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++; if (outv !== want) begin errors++; $display("FAIL load_use[%0d] outputs got %b want %b", i, outv, want); end
            checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL load_use[%0d] stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt); end
            if (!want[4]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t s[4];
        logic [5:0] e[4];
        logic [5:0] want;
        s[0] = mk(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); e[0] = BR;
        s[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); e[1] = BR;
        s[2] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0); e[2] = HOLD;
        s[3] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0); e[3] = BR;
        for (int i = 0; i < 4; i++) begin
            apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++; if (outv !== want) begin errors++; $display("FAIL branch[%0d] outputs got %b want %b", i, outv, want); end
            checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL branch[%0d] stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt); end
            if (!want[4]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t s;
        logic [5:0] e;
        logic [5:0] want;
        for (int i = 0; i < 7; i++) begin
            s = idle();
            s.ma = (i <= 5);
            s.mk = (i == 5);
            e = (i < 5) ? HOLD : NORM;
            apply(s); exp_q.push_back(e);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++; if (outv !== want) begin errors++; $display("FAIL mem_wait[%0d] outputs got %b want %b", i, outv, want); end
            checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL mem_wait[%0d] stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt); end
            checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL mem_wait[%0d] mem_timeout got %b want 0", i, mem_timeout); end
            if (!want[4]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        logic [5:0] e;
        logic [5:0] want;
        tmo_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            s = idle();
            s.ma = (i <= 10);
            s.mk = (i == 10);
            e = (i < 10) ? HOLD : NORM;
            apply(s); exp_q.push_back(e);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++; if (outv !== want) begin errors++; $display("FAIL timeout[%0d] outputs got %b want %b", i, outv, want); end
            checks++; if (t_hold !== want[1]) begin errors++; $display("FAIL timeout[%0d] t_hold got %b want %b", i, t_hold, want[1]); end
            checks++; if (t_mem_timeout !== (i >= 5)) begin errors++; $display("FAIL timeout[%0d] t_mem_timeout got %b want %b", i, t_mem_timeout, (i >= 5)); end
            checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout[%0d] mem_timeout got %b want 0", i, mem_timeout); end
            if (!want[4]) exp_cnt++;
            @(posedge clk); #1;
        end
        tmo_en = 1'b0;
        apply(idle());
    endtask

    task automatic test_halt();
        logic [5:0] e[7];
        logic [5:0] want;
        e = '{BUB, BUB, BUB, HLT, HLT, BUB, NORM};
        for (int i = 0; i < 7; i++) begin
            apply(req(i < 5)); exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++; if (outv !== want) begin errors++; $display("FAIL halt[%0d] outputs got %b want %b", i, outv, want); end
            checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL halt[%0d] stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt); end
            if (!want[4]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt_drain_events();
        stim_t s[7];
        logic [5:0] e[7];
        logic [5:0] want;
        s[0] = req(1'b1);                                                        e[0] = BUB;
        s[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); e[1] = DRNH;
        s[2] = req(1'b0);                                                        e[2] = BUB;
        s[3] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); e[3] = BUB;
        s[4] = req(1'b1);                                                        e[4] = HLT;
        s[5] = req(1'b0);                                                        e[5] = BUB;
        s[6] = idle();                                                           e[6] = NORM;
        for (int i = 0; i < 7; i++) begin
            apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++; if (outv !== want) begin errors++; $display("FAIL drain_events[%0d] outputs got %b want %b", i, outv, want); end
            checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL drain_events[%0d] stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt); end
            if (!want[4]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt_defer();
        stim_t s[21];
        logic [5:0] e[21];
        logic [5:0] want;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 7; j++) begin
                s[k*7+j] = req(j < 5);
                e[k*7+j] = (j == 4) ? HLT : (j == 6) ? NORM : BUB;
            end
        end
        s[0]  = mk(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        s[7]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1); e[7]  = BR;
        s[14] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); e[14] = HOLD;
        s[15] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            s[k*7+4] = req(1'b1);
            s[k*7+5] = req(1'b0);
            s[k*7+6] = idle();
        end
        for (int i = 0; i < 21; i++) begin
            apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++; if (outv !== want) begin errors++; $display("FAIL halt_defer[%0d] outputs got %b want %b", i, outv, want); end
            checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL halt_defer[%0d] stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt); end
            if (!want[4]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [5:0] e[7];
        logic [5:0] want;
        for (int i = 0; i < 2; i++) begin
            apply(req(1'b1)); exp_q.push_back(BUB);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++; if (outv !== want) begin errors++; $display("FAIL mid_drain[%0d] outputs got %b want %b", i, outv, want); end
            if (!want[4]) exp_cnt++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        apply(idle());
        #1;
        checks++; if (outv !== BUB) begin errors++; $display("FAIL mid_drain_rst outputs got %b want %b", outv, BUB); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_drain_rst stall_cnt got %0d want 0", stall_cnt); end
        checks++; if (t_mem_timeout !== 1'b0) begin errors++; $display("FAIL mid_drain_rst t_mem_timeout got %b want 0", t_mem_timeout); end
        exp_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        e = '{NORM, BUB, BUB, BUB, HLT, BUB, NORM};
        for (int i = 0; i < 7; i++) begin
            apply(req(i >= 1 && i <= 4)); exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++; if (outv !== want) begin errors++; $display("FAIL after_rst[%0d] outputs got %b want %b", i, outv, want); end
            checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL after_rst[%0d] stall_cnt got %0d want %0d", i, stall_cnt, exp_cnt); end
            if (!want[4]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        tmo_en = 1'b0;
        apply(idle());
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_halt_drain_events();
        test_halt_defer();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
